// File: rtl/muxn_arb.sv
// N-channel ready/valid multiplexer with a single registered output slot.
// Mode 0 forwards the channel picked by sel; mode 1 arbitrates round-robin.
module muxn_arb #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int S = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [S-1:0]   sel,
  output logic [W-1:0]   out_data,
  output logic [S-1:0]   out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [S:0] NS = (S+1)'(N);

  logic [W-1:0] r_data;
  logic [S-1:0] r_ch;
  logic         r_valid;
  logic [S-1:0] r_ptr;

  logic         w_load;
  logic         w_found;
  logic [S-1:0] w_gnt;
  logic [W-1:0] w_data;
  logic [2*N-1:0] w_dbl;
  logic [S:0]   w_off;
  logic [S:0]   w_sum;
  logic         w_rr_found;

  assign w_load = !r_valid || out_ready;

  // Rotate the request vector so bit j is channel (ptr+1+j) mod N.
  assign w_dbl = {in_valid, in_valid} >> ((S+1)'(r_ptr) + (S+1)'(1));

  always_comb begin
    w_rr_found = 1'b0;
    w_off      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_dbl[N-1-k]) begin
        w_rr_found = 1'b1;
        w_off      = (S+1)'(N - k);
      end
    end
    w_sum = (S+1)'(r_ptr) + w_off;
    if (w_sum >= NS) w_sum = w_sum - NS;
  end

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    if (mode) begin
      w_found = w_rr_found;
      w_gnt   = w_sum[S-1:0];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (sel == S'(k) && in_valid[k]) begin
          w_found = 1'b1;
          w_gnt   = sel;
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_gnt == S'(k)) w_data = in_data[k*W +: W];
    end
  end

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rst_n && w_load && w_found && w_gnt == S'(k)) in_ready[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= S'(N - 1);
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_ch    <= w_gnt;
        r_ptr   <= w_gnt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_muxn_arb.sv
// Self-checking bench for muxn_arb (N=4, W=4): directed table, reset corner
// sequence, and randomized traffic against a behavioural reference model.
module tb_muxn_arb;

  localparam int N = 4;
  localparam int W = 4;
  localparam int S = 2;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   sel;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_ch;
  logic           out_valid;
  logic           out_ready;

  int checks;
  int errors;

  muxn_arb #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          do_rst;
    bit          md;
    logic [1:0]  s;
    logic [3:0]  v;
    logic [15:0] d;
    bit          ordy;
    logic [3:0]  exp_ir;
    bit          exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_ch;
  } vec_t;

  // Reference grant: -1 when nothing is granted.
  function automatic int model_grant(bit md, int s, logic [3:0] v, int p);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int j = 1; j <= N; j++) begin
      int c;
      c = (p + j) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  vec_t tbl[$];

  initial begin
    int m_valid, m_data, m_ch, m_ptr;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;

    //            rst md s  valid    data      ordy ir       ov od      ch
    tbl.push_back('{0, 0, 1, 4'b0011, 16'h0035, 1, 4'b0010, 1, 4'h3, 1});
    tbl.push_back('{0, 0, 0, 4'b0011, 16'h0035, 1, 4'b0001, 1, 4'h5, 0});
    tbl.push_back('{1, 1, 0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h2, 1});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'h3, 2});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'h4, 3});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h2, 1});
    tbl.push_back('{0, 0, 2, 4'b1011, 16'h4321, 0, 4'b0000, 1, 4'h2, 1});
    tbl.push_back('{0, 0, 2, 4'b1011, 16'h4321, 1, 4'b0000, 0, 4'h2, 1});
    tbl.push_back('{0, 0, 2, 4'b1011, 16'h4321, 1, 4'b0000, 0, 4'h2, 1});
    tbl.push_back('{0, 1, 0, 4'b0000, 16'h4321, 1, 4'b0000, 0, 4'h2, 1});
    tbl.push_back('{0, 1, 0, 4'b0001, 16'h4321, 1, 4'b0001, 1, 4'h1, 0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_out_ch",    int'(out_ch), 0);
    check("rst_in_ready",  int'(in_ready), 0);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      mode = tbl[i].md; sel = tbl[i].s; in_valid = tbl[i].v;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].exp_ir));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].exp_ov));
      check($sformatf("vec%0d_out_data", i),  int'(out_data),  int'(tbl[i].exp_od));
      check($sformatf("vec%0d_out_ch", i),    int'(out_ch),    int'(tbl[i].exp_ch));
    end

    // Reset mid-stream: held word is dropped at once, ch0 regains priority.
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data",  int'(out_data), 0);
    check("midrst_in_ready",  int'(in_ready), 0);
    @(posedge clk); #1;
    check("midrst_hold_valid", int'(out_valid), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("postrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("postrst_out_data", int'(out_data), 1);
    check("postrst_out_ch",   int'(out_ch), 0);
    check("postrst_out_valid", int'(out_valid), 1);

    m_valid = 1; m_data = 1; m_ch = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g, ld, exp_ir;
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      g  = model_grant(mode, int'(sel), in_valid, m_ptr);
      ld = (!m_valid || out_ready) ? 1 : 0;
      exp_ir = (g >= 0 && ld != 0) ? (1 << g) : 0;
      check("rnd_in_ready",  int'(in_ready),  exp_ir);
      check("rnd_out_valid", int'(out_valid), m_valid);
      check("rnd_out_data",  int'(out_data),  m_data);
      check("rnd_out_ch",    int'(out_ch),    m_ch);
      @(posedge clk);
      if (ld != 0) begin
        if (g >= 0) begin
          m_valid = 1;
          m_data  = (int'(in_data) >> (g * W)) & ((1 << W) - 1);
          m_ch    = g;
          m_ptr   = g;
        end else begin
          m_valid = 0;
        end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
